// File: rtl/byte_deinterleaver.sv
// byte_deinterleaver: ping-pong block deinterleaver for DEPTH interleaved RS codewords.
// One bank fills in interleaved order while the other drains codeword by codeword.
//
// state    | meaning
// EMPTY    | bank holds no data, may accept the first byte of a frame
// FILLING  | bank is receiving a frame
// FULL     | complete frame stored, waiting for the read side
// DRAINING | frame is being read out; returns to EMPTY on the last output handshake
module byte_deinterleaver #(
  parameter int DEPTH = 2,
  parameter int N     = 255,
  parameter int K     = 223
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_axis_valid,
  output logic       s_axis_ready,
  input  logic [7:0] s_axis_data,
  input  logic       s_axis_sop,
  input  logic       s_axis_last,
  input  logic       s_axis_is_parity,
  output logic       m_axis_valid,
  input  logic       m_axis_ready,
  output logic [7:0] m_axis_data,
  output logic       m_axis_sop,
  output logic       m_axis_last,
  output logic       m_axis_is_parity,
  output logic       frame_err
);

  localparam int FRAME = DEPTH * N;
  localparam int AW    = $clog2(FRAME);
  localparam int DW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int JW    = $clog2(N);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

  bank_state_t   bank_q [2];
  bank_state_t   bank_d [2];

  logic          ready_en;
  logic          wr_bank;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] wr_addr;
  logic          accept;
  logic          restart;
  logic          wr_last;

  logic          iss_bank;
  logic          iss_busy;
  logic [DW-1:0] iss_d;
  logic [JW-1:0] iss_j;
  logic [AW-1:0] iss_addr;
  logic          j_end;
  logic          d_end;
  logic          iss_eof;
  logic          space;
  logic          rd_go;
  logic          start_drain;

  logic [7:0]    mem [0:(1 << (AW + 1)) - 1];
  logic [7:0]    rd_q;
  logic [3:0]    rd_meta;
  logic          rd_vld;

  logic [11:0]   fifo_q [2];
  logic          fifo_wp;
  logic          fifo_rp;
  logic [1:0]    fifo_cnt;
  logic [11:0]   head;
  logic          pop;
  logic          out_bank;
  logic          out_done;

  logic          unused_parity;
  assign unused_parity = s_axis_is_parity;

  // write side
  assign accept  = s_axis_valid && s_axis_ready;
  assign restart = s_axis_sop && (wr_idx != '0);
  assign wr_addr = restart ? '0 : wr_idx;
  assign wr_last = (wr_addr == AW'(FRAME - 1));

  // read issue: address j*DEPTH+d built by stepping, never by division
  assign j_end       = (iss_j == JW'(N - 1));
  assign d_end       = (iss_d == DW'(DEPTH - 1));
  assign iss_eof     = j_end && d_end;
  // outstanding entries after this edge must fit the 2-entry prefetch
  assign space       = ({1'b0, fifo_cnt} + {2'b0, rd_vld}) <= (3'd1 + {2'b0, pop});
  assign rd_go       = space && (iss_busy || (bank_q[iss_bank] == FULL));
  assign start_drain = rd_go && !iss_busy;

  assign head     = fifo_q[fifo_rp];
  assign pop      = m_axis_valid && m_axis_ready;
  assign out_done = pop && head[11];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
    end else begin
      bank_q <= bank_d;
    end
  end

  always_comb begin
    bank_d = bank_q;
    if (accept)      bank_d[wr_bank]  = wr_last ? FULL : FILLING;
    if (start_drain) bank_d[iss_bank] = DRAINING;
    if (out_done)    bank_d[out_bank] = EMPTY;
  end

  always_comb begin
    s_axis_ready = ready_en &&
                   ((bank_q[wr_bank] == EMPTY) || (bank_q[wr_bank] == FILLING));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      wr_bank   <= 1'b0;
      wr_idx    <= '0;
      frame_err <= 1'b0;
    end else begin
      ready_en  <= 1'b1;
      frame_err <= accept && (restart || (s_axis_last != wr_last));
      if (accept) begin
        if (wr_last) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx  <= wr_addr + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_bank <= 1'b0;
      iss_busy <= 1'b0;
      iss_d    <= '0;
      iss_j    <= '0;
      iss_addr <= '0;
    end else if (rd_go) begin
      if (iss_eof) begin
        iss_busy <= 1'b0;
        iss_bank <= ~iss_bank;
        iss_d    <= '0;
        iss_j    <= '0;
        iss_addr <= '0;
      end else begin
        iss_busy <= 1'b1;
        if (j_end) begin
          iss_j    <= '0;
          iss_d    <= iss_d + DW'(1);
          iss_addr <= AW'(iss_d) + AW'(1);
        end else begin
          iss_j    <= iss_j + JW'(1);
          iss_addr <= iss_addr + AW'(DEPTH);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[{wr_bank, wr_addr}] <= s_axis_data;
    if (rd_go)  rd_q <= mem[{iss_bank, iss_addr}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld  <= 1'b0;
      rd_meta <= '0;
    end else begin
      rd_vld <= rd_go;
      if (rd_go) rd_meta <= {iss_eof, (iss_j >= JW'(K)), j_end, (iss_j == '0)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      fifo_wp   <= 1'b0;
      fifo_rp   <= 1'b0;
      fifo_cnt  <= '0;
      out_bank  <= 1'b0;
    end else begin
      if (rd_vld) begin
        fifo_q[fifo_wp] <= {rd_meta, rd_q};
        fifo_wp         <= ~fifo_wp;
      end
      if (pop)      fifo_rp  <= ~fifo_rp;
      if (out_done) out_bank <= ~out_bank;
      fifo_cnt <= fifo_cnt + {1'b0, rd_vld} - {1'b0, pop};
    end
  end

  assign m_axis_valid     = (fifo_cnt != '0);
  assign m_axis_data      = m_axis_valid ? head[7:0] : 8'h00;
  assign m_axis_sop       = m_axis_valid && head[8];
  assign m_axis_last      = m_axis_valid && head[9];
  assign m_axis_is_parity = m_axis_valid && head[10];

endmodule
